// File: rtl/pipes_list.sv
// pipes_list: ordered, compacting list of pipe records with a one-entry-per-clock
// rewrite/remove iteration pass for the obstacle manager.
package pipes_pkg;
   typedef struct packed {
      logic [9:0] x;
      logic [5:0] gap_y;
   } pipe_t;
endpackage

module pipes_list #(
   parameter int CAPACITY = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce,
   output logic [4:0]        count,
   input  logic              insert_en,
   input  pipes_pkg::pipe_t  insert_data,
   input  logic              iter_start,
   output logic              iter_done,
   input  pipes_pkg::pipe_t  iter_in,
   output pipes_pkg::pipe_t  iter_out,
   input  logic              iter_remove
);
   import pipes_pkg::*;
   localparam int AW = (CAPACITY > 1) ? $clog2(CAPACITY) : 1;
   typedef enum logic {IDLE, ITER} state_t;
   state_t     r_state, w_next;
   pipe_t      r_mem [CAPACITY];
   logic [4:0] r_count, r_rd, r_wr;
   logic       w_ins, w_last;
   logic [4:0] w_count_ins;
   assign w_ins       = (r_state == IDLE) && insert_en && (r_count != 5'(CAPACITY));
   assign w_count_ins = r_count + (w_ins ? 5'd1 : 5'd0);
   assign w_last      = (r_rd == r_count - 5'd1);
   always_ff @(posedge clk) begin
      if (rst)
         r_state <= IDLE;
      else if (ce)
         r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      if (r_state == IDLE)
         w_next = (iter_start && w_count_ins != 5'd0) ? ITER : IDLE;
      else
         w_next = w_last ? IDLE : ITER;
   end
   always_comb begin
      iter_done = (r_state == IDLE);
      iter_out  = r_mem[(r_state == ITER) ? r_rd[AW-1:0] : '0];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= 5'd0;
         r_rd    <= 5'd0;
         r_wr    <= 5'd0;
      end else if (ce) begin
         if (r_state == IDLE) begin
            r_count <= w_count_ins;
            if (iter_start) begin
               r_rd <= 5'd0;
               r_wr <= 5'd0;
            end
         end else begin
            r_rd <= r_rd + 5'd1;
            if (!iter_remove)
               r_wr <= r_wr + 5'd1;
            // final wr after this entry becomes the compacted length
            if (w_last)
               r_count <= iter_remove ? r_wr : r_wr + 5'd1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!rst && ce) begin
         if (w_ins)
            r_mem[r_count[AW-1:0]] <= insert_data;
         else if (r_state == ITER && !iter_remove)
            r_mem[r_wr[AW-1:0]] <= iter_in;
      end
   end
   assign count = r_count;
endmodule

// File: tb/tb_pipes_list.sv
// tb_pipes_list: directed self-checking bench for pipes_list.
module tb_pipes_list;
   import pipes_pkg::*;
   logic        clk = 0, rst = 1, ce = 1;
   logic        insert_en = 0, iter_start = 0, iter_remove = 0, inc = 0;
   logic [15:0] insert_data = '0;
   logic [4:0]  count;
   logic        iter_done;
   pipe_t       iter_in, iter_out;
   int          n_cmp = 0, n_bad = 0;

   always #5 clk = ~clk;

   assign iter_in = inc ? pipe_t'(iter_out + 16'd1) : iter_out;

   pipes_list dut (
      .clk(clk), .rst(rst), .ce(ce), .count(count),
      .insert_en(insert_en), .insert_data(pipe_t'(insert_data)),
      .iter_start(iter_start), .iter_done(iter_done),
      .iter_in(iter_in), .iter_out(iter_out), .iter_remove(iter_remove)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input int v);
      insert_en = 1; insert_data = 16'(v);
      step();
      insert_en = 0;
   endtask

   task automatic do_pass(input string tag, input bit rm_first, input int n,
                          input int e0, input int e1, input int e2, input int e3);
      int ev[4];
      int busy = 0;
      ev = '{e0, e1, e2, e3};
      iter_start = 1;
      step();
      iter_start = 0;
      while (!iter_done && busy < 40) begin
         if (busy < 4 && busy < n) check({tag, "_out"}, int'(iter_out), ev[busy]);
         iter_remove = rm_first && busy == 0;
         step();
         busy++;
      end
      iter_remove = 0;
      check({tag, "_busy"}, busy, n);
      check({tag, "_done"}, int'(iter_done), 1);
   endtask

   initial begin
      step(); step();
      rst = 0;
      check("rst_count", int'(count), 0);
      check("rst_done", int'(iter_done), 1);
      for (int i = 1; i <= 4; i++) put(i);
      check("ins4_count", int'(count), 4);
      check("ins4_done", int'(iter_done), 1);
      do_pass("id1", 0, 4, 1, 2, 3, 4);
      check("id1_count", int'(count), 4);
      do_pass("id2", 0, 4, 1, 2, 3, 4);
      inc = 1;
      for (int p = 0; p < 4; p++) do_pass("inc", 0, 4, 1 + p, 2 + p, 3 + p, 4 + p);
      inc = 0;
      do_pass("after_inc", 0, 4, 5, 6, 7, 8);
      do_pass("rm1", 1, 4, 5, 6, 7, 8);
      check("rm1_count", int'(count), 3);
      do_pass("rm2", 1, 3, 6, 7, 8, 0);
      check("rm2_count", int'(count), 2);
      do_pass("rm3", 1, 2, 7, 8, 0, 0);
      check("rm3_count", int'(count), 1);
      do_pass("rm4", 1, 1, 8, 0, 0, 0);
      check("rm4_count", int'(count), 0);
      do_pass("empty", 0, 0, 0, 0, 0, 0);
      check("empty_count", int'(count), 0);
      put(1);
      do_pass("one", 0, 1, 1, 0, 0, 0);
      check("one_count", int'(count), 1);
      // insert and start in the same cycle: pass includes the new entry
      insert_en = 1; insert_data = 16'd9;
      do_pass("ins_start", 0, 2, 1, 9, 0, 0);
      insert_en = 0;
      check("ins_start_count", int'(count), 2);

      rst = 1; step(); rst = 0;
      for (int i = 0; i < 16; i++) put(100 + i);
      check("full16_count", int'(count), 16);
      put(999);
      check("full17_count", int'(count), 16);
      do_pass("full", 0, 16, 100, 101, 102, 103);
      check("full_pass_count", int'(count), 16);

      rst = 1; step(); rst = 0;
      put(1); put(2);
      iter_start = 1; step(); iter_start = 0;
      insert_en = 1; insert_data = 16'd77;
      step(); step();
      insert_en = 0;
      check("drop_done", int'(iter_done), 1);
      check("drop_count", int'(count), 2);
      do_pass("drop", 0, 2, 1, 2, 0, 0);

      put(3);
      iter_start = 1; step(); iter_start = 0;
      check("ce_out0", int'(iter_out), 1);
      step();
      check("ce_out1", int'(iter_out), 2);
      ce = 0; step();
      check("ce_frz1", int'(iter_out), 2);
      check("ce_frz_done", int'(iter_done), 0);
      step();
      check("ce_frz2", int'(iter_out), 2);
      ce = 1; step();
      check("ce_out2", int'(iter_out), 3);
      step();
      check("ce_end_done", int'(iter_done), 1);
      check("ce_end_count", int'(count), 3);

      iter_start = 1; step(); iter_start = 0;
      step();
      rst = 1; step(); rst = 0;
      check("midrst_count", int'(count), 0);
      check("midrst_done", int'(iter_done), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
